// File: rtl/clk_div_pkg.sv
// Shared helpers for the programmable clock divider: channel-index width
// and divisor clamping.
package clk_div_pkg;

  function automatic int calc_chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A zero divisor has no meaning; it is stored as the fastest legal rate.
  function automatic int unsigned clamp_div(input int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor, divided clock and
// a toggle strobe, all registered.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int RESET_DIV = 100
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run_i,
  input  logic             upd_i,
  input  logic [WIDTH-1:0] upd_div_i,
  output logic             pend_o,
  output logic             clk_o,
  output logic             tick_o
);

  localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_p_q, div_p_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             terminal;

  assign terminal = (cnt_q == div_a_q - ONE);

  // A new divisor only takes effect on a half-period boundary (or at once
  // when stopped), so no half-period is ever cut short.
  always_comb begin
    cnt_d   = cnt_q;
    div_a_d = div_a_q;
    div_p_d = div_p_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    if (!run_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
      if (pend_q) begin
        div_a_d = div_p_q;
        pend_d  = 1'b0;
      end
    end else if (terminal) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = 1'b1;
      if (pend_q) begin
        div_a_d = div_p_q;
        pend_d  = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + ONE;
    end
    // Acceptance requires pend_q == 0, so it never collides with an apply.
    if (upd_i && !pend_q) begin
      div_p_d = upd_div_i;
      pend_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      div_a_q <= DIV_RST;
      div_p_q <= DIV_RST;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_a_q <= div_a_d;
      div_p_q <= div_p_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign pend_o = pend_q;
  assign clk_o  = clk_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider: config decode, ready mux and
// one independent divider instance per channel.
module prog_clk_divider
  import clk_div_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 16,
  parameter int RESET_DIV = 100
) (
  input  logic                            clk_in,
  input  logic                            rst,
  input  logic [CHANNELS-1:0]             run_en,
  input  logic                            cfg_valid,
  input  logic [calc_chw(CHANNELS)-1:0]   cfg_chan,
  input  logic [WIDTH-1:0]                cfg_div,
  output logic                            cfg_ready,
  output logic [CHANNELS-1:0]             clk_out,
  output logic [CHANNELS-1:0]             tick
);

  localparam int CHW = calc_chw(CHANNELS);

  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] upd;
  logic [WIDTH-1:0]    div_clamped;

  assign div_clamped = WIDTH'(clamp_div(32'(cfg_div)));

  // Handshake: an update transfers when cfg_valid && cfg_ready; an index
  // beyond the last channel always reads ready and is dropped.
  always_comb begin
    cfg_ready = 1'b1;
    upd       = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CHW'(i)) begin
        cfg_ready = ~pend[i];
        upd[i]    = cfg_valid & ~pend[i];
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    clk_div_chan #(
      .WIDTH     (WIDTH),
      .RESET_DIV (RESET_DIV)
    ) u_chan (
      .clk_in    (clk_in),
      .rst       (rst),
      .run_i     (run_en[g]),
      .upd_i     (upd[g]),
      .upd_div_i (div_clamped),
      .pend_o    (pend[g]),
      .clk_o     (clk_out[g]),
      .tick_o    (tick[g])
    );
  end

endmodule

// File: doc/prog_clk_divider.md
PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4: number of independent divider channels.
REQ-002 The block SHALL have parameter WIDTH, default 16: divisor and counter width in bits.
REQ-003 The block SHALL have parameter RESET_DIV, default 100: divisor loaded into every channel at reset, range 1..2^WIDTH-1.
REQ-004 The block SHALL have port clk_in  input  1  source clock.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port run_en  input  CHANNELS  per-channel run enable.
REQ-007 The block SHALL have port cfg_valid  input  1  divisor update request.
REQ-008 The block SHALL have port cfg_chan  input  CHW = max(1, clog2(CHANNELS))  target channel index.
REQ-009 The block SHALL have port cfg_div  input  WIDTH  new divisor.
REQ-010 The block SHALL have port cfg_ready  output  1  update can be accepted.
REQ-011 The block SHALL have port clk_out  output  CHANNELS  divided clock per channel.
REQ-012 The block SHALL have port tick  output  CHANNELS  one-cycle strobe on each clk_out toggle.

Function
REQ-013 Each channel SHALL hold an active divisor div_a, a counter cnt, a pending divisor div_p and a pending flag pend.
REQ-014 While run_en[i]=1: if cnt==div_a-1, then cnt<=0, clk_out[i] toggles and tick[i]=1 for that cycle; otherwise cnt<=cnt+1 and tick[i]=0.
REQ-015 clk_out[i] period SHALL be 2*div_a clk_in cycles at 50% duty; div_a=1 gives clk_in/2.
REQ-016 tick[i] SHALL be registered and asserted in the same cycle clk_out[i] changes.
REQ-017 While run_en[i]=0: cnt<=0, clk_out[i]<=0, tick[i]=0.
REQ-018 After run_en[i] rises, the first toggle SHALL occur div_a cycles later.
REQ-019 cfg_ready SHALL be combinational and equal ~pend[cfg_chan].
REQ-020 An update is accepted when cfg_valid && cfg_ready; then div_p<=cfg_div and pend<=1 for channel cfg_chan.
REQ-021 cfg_chan >= CHANNELS SHALL be ignored: cfg_ready=1 and no state changes.
REQ-022 cfg_div=0 SHALL be stored as 1.
REQ-023 A running channel with pend=1 SHALL apply div_p at its terminal count: div_a<=div_p and pend<=0 in the toggle cycle; the next half-period uses the new divisor.
REQ-024 A stopped channel with pend=1 SHALL apply div_p on the next clk_in edge.
REQ-025 When an acceptance and a terminal count coincide on a channel with pend=0, the new value SHALL become pending and be applied at the following terminal count, not in the same cycle.
REQ-026 The counter SHALL never exceed div_a-1; divisor changes SHALL never produce a shortened or runt half-period.
REQ-027 Channels SHALL be fully independent; an update to one channel SHALL NOT disturb another channel's cnt, clk_out or tick.

Reset
REQ-028 On rst=1, each channel SHALL asynchronously set cnt=0, clk_out=0, tick=0, div_a=RESET_DIV, div_p=RESET_DIV and pend=0; cfg_ready therefore reads 1.
REQ-029 Reset asserted mid-period or with an update pending SHALL discard the pending divisor and restart from RESET_DIV.
REQ-030 Reset release SHALL be synchronous to clk_in; the first count SHALL occur on the first clk_in edge after release with run_en high.

Structure
REQ-031 Package clk_div_pkg SHALL hold the CHW computation function and the divisor clamp helper used by REQ-022.
REQ-032 Sub-module clk_div_chan SHALL implement one channel (cnt, div_a, div_p, pend, clk_out, tick) and SHALL be instantiated CHANNELS times by a generate loop.
REQ-033 The top level SHALL contain only cfg decode, cfg_ready mux and the instances; outputs SHALL be registered, with no combinational path from inputs to clk_out or tick.

Verification
REQ-034 Reset, then run_en=4'b0001 with RESET_DIV=100 -> clk_out[0] toggles every 100 cycles, tick[0] pulses once per toggle, other channels stay 0.
REQ-035 With ch0 running at div 4, write cfg_div=2 mid-half-period -> current half-period completes at 4 cycles, then half-periods of 2; cfg_ready for ch0 is low until the applying toggle.
REQ-036 Write cfg_div=0 to stopped ch1, then raise run_en[1] -> clk_out[1] toggles every cycle (clk_in/2).
REQ-037 Assert cfg_valid in the exact terminal-count cycle of ch2 (div 5, new 3) -> next half-period is 5 cycles, then 3.
REQ-038 Assert rst mid-period with ch3 pend=1 (div_p=7) -> all outputs 0 immediately; after release ch3 divides by 100 and cfg_ready=1.
REQ-039 Drop run_en[0] while clk_out[0]=1 and re-raise it 3 cycles later -> clk_out[0] reads 0 while low; first toggle occurs div_a cycles after the re-raise.
